// File: rtl/rng_uart_tx.sv
// rng_uart_tx: packs synchronized RNG bits into words and sends them as 8N1 UART frames.
// Define RNG_VON_NEUMANN_EN to debias raw bit pairs before packing.
module rng_uart_tx #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        done,
  input  logic        rnd_bit,
  output logic        tx,
  output logic        tx_busy,
  output logic        ovf,
  output logic [15:0] bytes_sent
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int CW  = $clog2(DATA_BITS);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [1:0] done_q, rnd_q;
  logic done_d, acc, in_v, in_b, offer, drain, baud_end, hold_full;
  logic [DATA_BITS-2:0] word;
  logic [DATA_BITS-1:0] word_n, hold, sh;
  logic [CW-1:0] cnt, idx;
  logic [BW-1:0] baud;
  assign acc = done_q[1] & ~done_d;
`ifdef RNG_VON_NEUMANN_EN
  logic ph, a;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      ph <= 1'b0;
      a  <= 1'b0;
    end else if (acc) begin
      ph <= ~ph;
      if (!ph) a <= rnd_q[1];
    end
  // (0,1)->0 and (1,0)->1: the delivered bit is simply the first of an unequal pair
  assign in_v = acc & ph & (a ^ rnd_q[1]);
  assign in_b = a;
`else
  assign in_v = acc;
  assign in_b = rnd_q[1];
`endif
  assign word_n   = {in_b, word};
  assign offer    = in_v && cnt == CW'(DATA_BITS - 1);
  assign baud_end = baud == BW'(DIV - 1);
  assign tx       = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
  assign tx_busy  = state != IDLE;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      done_q    <= '0;
      rnd_q     <= '0;
      done_d    <= 1'b0;
      word      <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done_q <= {done_q[0], done};
      rnd_q  <= {rnd_q[0], rnd_bit};
      done_d <= done_q[1];
      if (in_v) begin
        word <= word_n[DATA_BITS-1:1];
        cnt  <= offer ? '0 : cnt + 1'b1;
      end
      if (offer && (!hold_full || drain)) begin
        hold      <= word_n;
        hold_full <= 1'b1;
      end else if (offer) ovf <= 1'b1;
      else if (drain) hold_full <= 1'b0;
    end
  always_comb begin
    state_n = state;
    drain   = 1'b0;
    case (state)
      IDLE:  if (hold_full) begin
        state_n = START;
        drain   = 1'b1;
      end
      START: if (baud_end) state_n = DATA;
      DATA:  if (baud_end && idx == CW'(DATA_BITS - 1)) state_n = STOP;
      STOP:  if (baud_end) begin
        state_n = hold_full ? START : IDLE;
        drain   = hold_full;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      baud       <= '0;
      idx        <= '0;
      sh         <= '0;
      bytes_sent <= '0;
    end else begin
      baud <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
      if (drain) sh <= hold;
      else if (state == DATA && baud_end) sh <= sh >> 1;
      if (state == START) idx <= '0;
      else if (state == DATA && baud_end) idx <= idx + 1'b1;
      if (state == STOP && baud_end) bytes_sent <= bytes_sent + 1'b1;
    end
endmodule
